pipe_adder: RTL

Parametrised, pipelined integer adder/subtractor for the MIPS datapath, the successor to the single-cycle 32-bit combinational adder. It splits a WIDTH-bit add/sub into STAGES carry-chained slices, registering between slices to shorten the critical path. It carries a valid/ready handshake, a pass-through tag and a synchronous flush for squashing wrong-path instructions. It also produces carry, zero and signed-overflow flags for the EX stage.

---
 rtl/alu_pkg.sv | 13 +
 rtl/add_slice.sv | 27 ++
 rtl/pipe_adder.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: constants shared by the integer datapath blocks.
//   ALU_WIDTH - default operand/result width
//   ALU_TAG_W - width of the destination-register tag carried with an op
//   OP_ADD / OP_SUB - encoding of the add/subtract select bit
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;
  localparam int unsigned ALU_TAG_W = 5;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/add_slice.sv
// add_slice: combinational SW-bit adder slice with carry-in.
// Ports:
//   a_i, b_i  - slice operands (b_i is already inverted for subtraction)
//   cin_i     - carry into bit 0 of the slice
//   sum_o     - slice sum
//   cout_o    - carry out of the slice MSB
//   cmsb_o    - carry into the slice MSB (cmsb ^ cout gives signed overflow)
module add_slice #(
  parameter int unsigned SW = 16
) (
  input  logic [SW-1:0] a_i,
  input  logic [SW-1:0] b_i,
  input  logic          cin_i,
  output logic [SW-1:0] sum_o,
  output logic          cout_o,
  output logic          cmsb_o
);

  logic [SW:0] res;

  assign res    = {1'b0, a_i} + {1'b0, b_i} + {{SW{1'b0}}, cin_i};
  assign sum_o  = res[SW-1:0];
  assign cout_o = res[SW];
  // Sum bit = a ^ b ^ carry-in, so the MSB carry-in falls out of the sum.
  assign cmsb_o = res[SW-1] ^ a_i[SW-1] ^ b_i[SW-1];

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined WIDTH-bit integer adder/subtractor with valid/ready handshake.
// The add is split into STAGES slices of SW = WIDTH/STAGES bits; stage k adds slice k using
// the carry registered by stage k-1. Lower result slices and the not-yet-added upper operand
// slices travel with the op. The whole pipe moves together (global advance), so a stalled
// output freezes every stage.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   flush               - squash all in-flight ops at the next edge
//   in_valid/in_ready   - input handshake; in_ready = advance && !flush
//   in_a, in_b, in_sub  - operands and op select (0 = A+B, 1 = A-B)
//   in_signed, in_tag   - report signed overflow; opaque tag returned with the result
//   out_valid/out_ready - output handshake
//   out_sum, out_carry  - result mod 2^WIDTH; carry out (for sub, 1 = no borrow)
//   out_zero, out_ovf   - result is zero; signed overflow
//   out_tag             - tag of this result
// Configuration: define PIPE_ADDER_OVF_EN to build the overflow logic; otherwise out_ovf = 0.
// WIDTH must be a multiple of STAGES, and STAGES must be in 1..4.
module pipe_adder
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = ALU_WIDTH,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = ALU_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_signed,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned SW = WIDTH / STAGES;

  logic advance;
  logic sub_op;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance & ~flush;
  assign sub_op   = (in_sub == OP_SUB);

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    // Operand bits still to be added when the op reaches this stage.
    localparam int unsigned Rem = WIDTH - s * SW;

    logic [Rem-1:0]        a_src;
    logic [Rem-1:0]        b_src;
    logic                  cin_src;
    logic                  vld_src;
    logic [TAG_W-1:0]      tag_src;
    logic [SW-1:0]         slc_sum;
    logic                  slc_cout;
    logic                  slc_cmsb;
    logic [(s+1)*SW-1:0]   sum_nx;

    logic                  vld_q;
    logic                  cy_q;
    logic [TAG_W-1:0]      tag_q;
    logic [(s+1)*SW-1:0]   sum_q;
`ifdef PIPE_ADDER_OVF_EN
    logic                  sgn_src;
`endif

    if (s == 0) begin : g_src
      assign a_src   = in_a;
      assign b_src   = in_b ^ {WIDTH{sub_op}};
      assign cin_src = sub_op;
      assign vld_src = in_valid & in_ready;
      assign tag_src = in_tag;
      assign sum_nx  = slc_sum;
`ifdef PIPE_ADDER_OVF_EN
      assign sgn_src = in_signed;
`endif
    end else begin : g_src
      assign a_src   = g_stage[s-1].g_fwd.a_q;
      assign b_src   = g_stage[s-1].g_fwd.b_q;
      assign cin_src = g_stage[s-1].cy_q;
      assign vld_src = g_stage[s-1].vld_q;
      assign tag_src = g_stage[s-1].tag_q;
      assign sum_nx  = {slc_sum, g_stage[s-1].sum_q};
`ifdef PIPE_ADDER_OVF_EN
      assign sgn_src = g_stage[s-1].g_fwd.sgn_q;
`endif
    end

    add_slice #(
      .SW(SW)
    ) u_slice (
      .a_i   (a_src[SW-1:0]),
      .b_i   (b_src[SW-1:0]),
      .cin_i (cin_src),
      .sum_o (slc_sum),
      .cout_o(slc_cout),
      .cmsb_o(slc_cmsb)
    );

    // flush beats advance for the valid bit; data only moves with advance.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
        tag_q <= '0;
        sum_q <= '0;
      end else begin
        if (flush) begin
          vld_q <= 1'b0;
        end else if (advance) begin
          vld_q <= vld_src;
        end
        if (advance) begin
          cy_q  <= slc_cout;
          tag_q <= tag_src;
          sum_q <= sum_nx;
        end
      end
    end

    if (s == STAGES - 1) begin : g_last
      logic zero_q;
`ifdef PIPE_ADDER_OVF_EN
      logic ovf_q;
`else
      logic unused_cmsb;
      assign unused_cmsb = slc_cmsb;
`endif

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          zero_q <= 1'b0;
`ifdef PIPE_ADDER_OVF_EN
          ovf_q  <= 1'b0;
`endif
        end else if (advance) begin
          zero_q <= (sum_nx == '0);
`ifdef PIPE_ADDER_OVF_EN
          // Carry into MSB differing from carry out is the classic signed overflow test.
          ovf_q  <= sgn_src & (slc_cmsb ^ slc_cout);
`endif
        end
      end
    end else begin : g_fwd
      logic [Rem-SW-1:0] a_q;
      logic [Rem-SW-1:0] b_q;
      logic              unused_cmsb;
`ifdef PIPE_ADDER_OVF_EN
      logic              sgn_q;
`endif

      assign unused_cmsb = slc_cmsb;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q   <= '0;
          b_q   <= '0;
`ifdef PIPE_ADDER_OVF_EN
          sgn_q <= 1'b0;
`endif
        end else if (advance) begin
          a_q   <= a_src[Rem-1:SW];
          b_q   <= b_src[Rem-1:SW];
`ifdef PIPE_ADDER_OVF_EN
          sgn_q <= sgn_src;
`endif
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].vld_q;
  assign out_sum   = g_stage[STAGES-1].sum_q;
  assign out_carry = g_stage[STAGES-1].cy_q;
  assign out_tag   = g_stage[STAGES-1].tag_q;
  assign out_zero  = g_stage[STAGES-1].g_last.zero_q;

`ifdef PIPE_ADDER_OVF_EN
  assign out_ovf = g_stage[STAGES-1].g_last.ovf_q;
`else
  logic unused_signed;
  assign unused_signed = in_signed;
  assign out_ovf       = 1'b0;
`endif

endmodule
